// File: rtl/voice_mixer.sv
// rtl/voice_mixer.sv - sequential per-frame voice sample mixer with registered output
// Optional output clamp: define VOICE_MIXER_SATURATE_EN; otherwise the sum wraps.

module cl_adder #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

module voice_mixer #(
   parameter int C_WIDTH      = 16,
   parameter int C_NUM_VOICES = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [C_WIDTH-1:0] s_data,
   output logic               m_valid,
   input  logic               m_ready,
   output logic [C_WIDTH-1:0] m_data,
   output logic               busy
);

   localparam int CNT_W = $clog2(C_NUM_VOICES);
   localparam int ACC_W = C_WIDTH + CNT_W;
   localparam logic [CNT_W-1:0] LAST_VOICE = CNT_W'(C_NUM_VOICES - 1);

   typedef enum logic {
      ACCUM  = 1'b0,
      OUTPUT = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [C_WIDTH-1:0] m_data_q, m_data_d;

   logic [ACC_W-1:0]   s_data_ext;
   logic [ACC_W-1:0]   sum;
   logic               add_cout_unused;
   logic [C_WIDTH-1:0] mix_result;

   assign s_data_ext = {{CNT_W{s_data[C_WIDTH-1]}}, s_data};

   cl_adder #(
      .W(ACC_W)
   ) u_acc_adder (
      .a    (acc_q),
      .b    (s_data_ext),
      .cin  (1'b0),
      .sum  (sum),
      .cout (add_cout_unused)
   );

`ifdef VOICE_MIXER_SATURATE_EN
   // In range only when every bit above the output sign bit matches it.
   always_comb begin
      mix_result = sum[C_WIDTH-1:0];
      if (!((&sum[ACC_W-1:C_WIDTH-1]) || !(|sum[ACC_W-1:C_WIDTH-1]))) begin
         if (sum[ACC_W-1]) begin
            mix_result = {1'b1, {(C_WIDTH-1){1'b0}}};
         end else begin
            mix_result = {1'b0, {(C_WIDTH-1){1'b1}}};
         end
      end
   end
`else
   assign mix_result = sum[C_WIDTH-1:0];
`endif

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      count_d  = count_q;
      m_data_d = m_data_q;
      s_ready  = (state_q == ACCUM);
      m_valid  = (state_q == OUTPUT);
      busy     = (count_q != '0) || (state_q == OUTPUT);
      case (state_q)
         ACCUM: begin
            if (s_valid) begin
               acc_d   = sum;
               count_d = count_q + CNT_W'(1);
               if (count_q == LAST_VOICE) begin
                  m_data_d = mix_result;
                  state_d  = OUTPUT;
               end
            end
         end
         OUTPUT: begin
            if (m_ready) begin
               acc_d   = '0;
               state_d = ACCUM;
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ACCUM;
         acc_q    <= '0;
         count_q  <= '0;
         m_data_q <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         count_q  <= count_d;
         m_data_q <= m_data_d;
      end
   end

   assign m_data = m_data_q;

endmodule

// File: doc/voice_mixer.md
# voice_mixer

Sums one signed sample per voice, for all synthesizer voices, into a single mixed output sample per frame. Sits directly downstream of the per-voice sample generators and upstream of the output DAC/I2S stage. Accumulation is sequential: one voice per accepted beat. The running sum is formed with the team's `cl_adder` at accumulator width. The result is clamped to the output width, or wrapped, depending on configuration.

## Interface
- `C_WIDTH`, 16, sample width in bits (signed two's complement, input and output)
- `C_NUM_VOICES`, 8, voices per frame; must be ≥2 and a power of two
- Derived: `ACC_W = C_WIDTH + $clog2(C_NUM_VOICES)`, the accumulator width

Ports:
- `clk` in 1, single clock, rising edge
- `reset_n` in 1, asynchronous assert, active-low reset (fixed)
- `s_valid` in 1, input sample valid
- `s_ready` out 1, mixer can accept a sample
- `s_data` in C_WIDTH, signed voice sample; voices arrive in order 0..C_NUM_VOICES-1
- `m_valid` out 1, mixed sample valid
- `m_ready` in 1, downstream accepts the mixed sample
- `m_data` out C_WIDTH, signed mixed sample
- `busy` out 1, high while a frame is partially accumulated (voice count ≠ 0) or a result is pending

## Operation
- State machine with two states, `ACCUM` and `OUTPUT`. Reset state is `ACCUM`.
- **`ACCUM` state**
  - `s_ready`=1, `m_valid`=0.
  - Input handshake = `s_valid & s_ready`.
  - On each handshake: `acc <= acc + sext(s_data)` and `count <= count + 1`.
  - The sum uses a `cl_adder` of width ACC_W. Both operands are sign-extended to ACC_W. The adder's carry-out bit is discarded.
- **Leaving `ACCUM`**
  - On the handshake where `count == C_NUM_VOICES-1`, the final add is performed and `count` wraps to 0.
  - In the same edge, `m_data` is registered from the new sum and the state moves to `OUTPUT`.
- **`OUTPUT` state**
  - `s_ready`=0, `m_valid`=1.
  - `m_data` is held stable until the output handshake `m_valid & m_ready`.
  - On the output handshake: `acc <= 0`, state returns to `ACCUM`.
- ACC_W always holds the exact sum of C_NUM_VOICES full-scale samples, so the accumulator never overflows internally.
- `busy` = (`count` ≠ 0) or (state == `OUTPUT`).
- No mid-frame abort exists; only reset discards a partial frame.
- **Reset (any time, including mid-frame):** `acc`=0, `count`=0, state `ACCUM`, `m_data`=0, `m_valid`=0, `busy`=0. `s_ready` reads 1 while in reset.

## Timing
- `m_valid` rises on the clock edge after the last voice is accepted: 1-cycle latency from the final input handshake.
- Minimum frame period is C_NUM_VOICES+1 cycles: N input beats plus 1 output beat with `m_ready` held high.
- `s_ready` and `m_valid` are direct decodes of the state register; neither depends combinationally on `s_valid` or `m_ready`.
- `s_valid` low in `ACCUM` stalls accumulation; `acc` and `count` hold.
- `m_ready` low in `OUTPUT` holds `m_data`, `m_valid`=1 and `s_ready`=0 indefinitely.
- `s_data` is ignored in `OUTPUT`, even if `s_valid` is high.
- `m_data` is registered; there is no combinational path from `s_data` to `m_data`.

## Configuration
- **Macro `VOICE_MIXER_SATURATE_EN` defined:** the final sum is clamped.
  - Sums above 2^(C_WIDTH-1)-1 produce exactly 2^(C_WIDTH-1)-1.
  - Sums below -2^(C_WIDTH-1) produce exactly -2^(C_WIDTH-1).
  - In-range sums pass through unchanged.
- **Macro undefined:** `m_data` = `acc[C_WIDTH-1:0]` (two's-complement wrap). No clamp logic is synthesized.

## Test plan
All cases use C_WIDTH=16, C_NUM_VOICES=4.
- **Basic mix:** feed 1000, 2000, -500, 250 back-to-back with `m_ready`=1 → `m_valid` on the cycle after the 4th beat, `m_data`=2750; `s_ready` low for exactly 1 cycle.
- **Positive overflow:** feed 20000 ×4 → `m_data`=32767 with the macro; 14464 without.
- **Negative overflow:** feed -20000 ×4 → `m_data`=-32768 with the macro; -14464 without.
- **Backpressure:** feed 1, 2, 3, 4 with `m_ready`=0 for 5 cycles → `m_data`=10 stable, `m_valid`=1, `s_ready`=0 throughout the stall. Then raise `m_ready` → the next frame 5, 5, 5, 5 gives 20 (accumulator cleared between frames).
- **Input gaps:** insert `s_valid`=0 bubbles of 3 cycles between each of 7, 7, 7, 7 → `m_data`=28; `busy` stays 1 from the first beat until the output handshake.
- **Reset mid-frame:** accept 100, 200, assert `reset_n`=0 for 2 cycles, then feed 1, 1, 1, 1 → `m_data`=4; all outputs at reset values while `reset_n` is low.
